// File: rtl/pe_cluster_sequencer.sv
// pe_cluster_sequencer
//   Load/compute/drain sequencer for an X-by-Y PE cluster. It sits between the
//   global buffer and the PE array.
//   - Load: walks the X/Y multicast tags over cfg_words_i words per PE. It
//     streams lockstep weight/activation reads over a req/gnt port, and
//     presents the returned data as cast_valid_o with its tags one cycle later.
//   - Compute: pulses pe_start_o, then waits for all columns to report done.
//   - Drain: pulses trigger_sums_o, then counts top-row psums and generates
//     output write addresses.
//   - flag_done_o pulses for one cycle after a load or drain completes.
//
// Ports
//   clk, nrst                  clock; asynchronous active-low reset
//   start_load_i               start a load (sampled in idle only)
//   start_compute_i            start a compute (sampled in idle only)
//   abort_i                    synchronous abort to idle from any state
//   cfg_w_base_i, cfg_a_base_i weight/activation base addresses
//   cfg_words_i                words per PE per load (0 allowed)
//   cfg_num_outs_i             psum words expected in drain
//   rd_req_o, rd_gnt_i         read request/grant; data returns 1 cycle after grant
//   w_rd_addr_o, a_rd_addr_o   read addresses
//   cast_valid_o               read data valid on the bus this cycle
//   tag_x_o, tag_y_o           multicast tags aligned to cast_valid_o
//   pe_start_o                 compute start pulse
//   pe_done_i                  per-column done
//   trigger_sums_o             psum accumulation trigger pulse
//   out_valid_i                top-row psum valid
//   out_addr_o                 output write address
//   flag_done_o                end-of-operation pulse
//   perf_cycles_o              busy-cycle count (PE_CLUSTER_PERF_EN only)
//
// Build option: define PE_CLUSTER_PERF_EN to add perf_cycles_o.
module pe_cluster_sequencer #(
  parameter int unsigned NUM_PE_X = 3,
  parameter int unsigned NUM_PE_Y = 3,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned ID_W     = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                start_load_i,
  input  logic                start_compute_i,
  input  logic                abort_i,
  input  logic [ADDR_W-1:0]   cfg_w_base_i,
  input  logic [ADDR_W-1:0]   cfg_a_base_i,
  input  logic [CNT_W-1:0]    cfg_words_i,
  input  logic [CNT_W-1:0]    cfg_num_outs_i,
  output logic                rd_req_o,
  input  logic                rd_gnt_i,
  output logic [ADDR_W-1:0]   w_rd_addr_o,
  output logic [ADDR_W-1:0]   a_rd_addr_o,
  output logic                cast_valid_o,
  output logic [ID_W-1:0]     tag_x_o,
  output logic [ID_W-1:0]     tag_y_o,
  output logic                pe_start_o,
  input  logic [NUM_PE_X-1:0] pe_done_i,
  output logic [NUM_PE_X-1:0] trigger_sums_o,
  input  logic                out_valid_i,
  output logic [CNT_W-1:0]    out_addr_o,
`ifdef PE_CLUSTER_PERF_EN
  output logic [31:0]         perf_cycles_o,
`endif
  output logic                flag_done_o
);

  typedef enum logic [2:0] {StIdle, StLoad, StCompute, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d, a_addr_q, a_addr_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0]  out_cnt_q, out_cnt_d, out_addr_q, out_addr_d;
  logic [ID_W-1:0]   tag_x_q, tag_x_d, tag_y_q, tag_y_d;
  logic [ID_W-1:0]   cast_x_q, cast_x_d, cast_y_q, cast_y_d;
  logic              cast_valid_q, cast_valid_d;
  logic              flag_q, flag_d;
  // High on the first cycle of compute and drain (start/trigger pulses).
  logic              first_q, first_d;
  logic              grant;
  logic              last_word, last_x, last_y;

  assign last_word = (word_cnt_q == cfg_words_i - CNT_W'(1));
  assign last_x    = (tag_x_q == ID_W'(NUM_PE_X - 1));
  assign last_y    = (tag_y_q == ID_W'(NUM_PE_Y - 1));

  always_comb begin
    state_d        = state_q;
    w_addr_d       = w_addr_q;
    a_addr_d       = a_addr_q;
    word_cnt_d     = word_cnt_q;
    out_cnt_d      = out_cnt_q;
    out_addr_d     = out_addr_q;
    tag_x_d        = tag_x_q;
    tag_y_d        = tag_y_q;
    cast_x_d       = cast_x_q;
    cast_y_d       = cast_y_q;
    cast_valid_d   = 1'b0;
    flag_d         = 1'b0;
    first_d        = 1'b0;
    grant          = 1'b0;
    rd_req_o       = 1'b0;
    pe_start_o     = 1'b0;
    trigger_sums_o = '0;

    unique case (state_q)
      StIdle: begin
        if (start_load_i) begin
          state_d    = StLoad;
          w_addr_d   = cfg_w_base_i;
          a_addr_d   = cfg_a_base_i;
          word_cnt_d = '0;
          tag_x_d    = '0;
          tag_y_d    = '0;
        end else if (start_compute_i) begin
          state_d = StCompute;
          first_d = 1'b1;
        end
      end

      StLoad: begin
        if (cfg_words_i == '0) begin
          state_d = StDone;
        end else begin
          rd_req_o = 1'b1;
          if (rd_gnt_i) begin
            grant    = 1'b1;
            w_addr_d = w_addr_q + ADDR_W'(1);
            a_addr_d = a_addr_q + ADDR_W'(1);
            if (last_word) begin
              word_cnt_d = '0;
              if (last_x) begin
                tag_x_d = '0;
                if (last_y) begin
                  tag_y_d = '0;
                  state_d = StDone;
                end else begin
                  tag_y_d = tag_y_q + ID_W'(1);
                end
              end else begin
                tag_x_d = tag_x_q + ID_W'(1);
              end
            end else begin
              word_cnt_d = word_cnt_q + CNT_W'(1);
            end
          end
        end
      end

      StCompute: begin
        pe_start_o = first_q;
        // Done flags may still be stale from the previous job in the start cycle.
        if (!first_q && (&pe_done_i)) begin
          state_d   = StDrain;
          first_d   = 1'b1;
          out_cnt_d = '0;
        end
      end

      StDrain: begin
        trigger_sums_o = {NUM_PE_X{first_q}};
        if (out_valid_i) begin
          out_addr_d = out_addr_q + CNT_W'(1);
          out_cnt_d  = out_cnt_q + CNT_W'(1);
        end
        if ((cfg_num_outs_i == '0) || (out_cnt_d == cfg_num_outs_i)) begin
          state_d = StDone;
        end
      end

      StDone: begin
        flag_d     = 1'b1;
        state_d    = StIdle;
        out_addr_d = '0;
        out_cnt_d  = '0;
      end

      default: state_d = StIdle;
    endcase

    // Capture the tags of the granted word so they line up with the returning data.
    cast_valid_d = grant;
    if (grant) begin
      cast_x_d = tag_x_q;
      cast_y_d = tag_y_q;
    end

    // A grant in the abort cycle is already in flight and still casts.
    if (abort_i) begin
      state_d    = StIdle;
      word_cnt_d = '0;
      out_cnt_d  = '0;
      out_addr_d = '0;
      tag_x_d    = '0;
      tag_y_d    = '0;
      flag_d     = 1'b0;
      first_d    = 1'b0;
      if (!grant) begin
        cast_x_d = '0;
        cast_y_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= StIdle;
      w_addr_q     <= '0;
      a_addr_q     <= '0;
      word_cnt_q   <= '0;
      out_cnt_q    <= '0;
      out_addr_q   <= '0;
      tag_x_q      <= '0;
      tag_y_q      <= '0;
      cast_x_q     <= '0;
      cast_y_q     <= '0;
      cast_valid_q <= 1'b0;
      flag_q       <= 1'b0;
      first_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      w_addr_q     <= w_addr_d;
      a_addr_q     <= a_addr_d;
      word_cnt_q   <= word_cnt_d;
      out_cnt_q    <= out_cnt_d;
      out_addr_q   <= out_addr_d;
      tag_x_q      <= tag_x_d;
      tag_y_q      <= tag_y_d;
      cast_x_q     <= cast_x_d;
      cast_y_q     <= cast_y_d;
      cast_valid_q <= cast_valid_d;
      flag_q       <= flag_d;
      first_q      <= first_d;
    end
  end

  assign w_rd_addr_o  = w_addr_q;
  assign a_rd_addr_o  = a_addr_q;
  assign cast_valid_o = cast_valid_q;
  assign tag_x_o      = cast_x_q;
  assign tag_y_o      = cast_y_q;
  assign out_addr_o   = out_addr_q;
  assign flag_done_o  = flag_q;

`ifdef PE_CLUSTER_PERF_EN
  // Busy cycles of the last operation, including its done cycle.
  logic [31:0] perf_q;
  logic        op_start;
  logic        busy;

  assign op_start = (state_q == StIdle) && !abort_i && (start_load_i || start_compute_i);
  assign busy     = (state_q != StIdle);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      perf_q <= '0;
    end else if (op_start) begin
      perf_q <= '0;
    end else if (busy && (perf_q != '1)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cycles_o = perf_q;
`endif

endmodule

// File: tb/tb_pe_cluster_sequencer.sv
module tb_pe_cluster_sequencer;

  logic        clk = 1'b0;
  logic        nrst;
  logic        start_load, start_compute, abort;
  logic [15:0] cfg_w_base, cfg_a_base;
  logic [7:0]  cfg_words, cfg_num_outs;
  logic        rd_req, rd_gnt;
  logic [15:0] w_addr, a_addr;
  logic        cast_valid;
  logic [7:0]  tag_x, tag_y;
  logic        pe_start;
  logic [2:0]  pe_done;
  logic [2:0]  trigger;
  logic        out_valid;
  logic [7:0]  out_addr;
  logic        flag_done;
`ifdef PE_CLUSTER_PERF_EN
  logic [31:0] perf;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pe_cluster_sequencer dut (
    .clk            (clk),
    .nrst           (nrst),
    .start_load_i   (start_load),
    .start_compute_i(start_compute),
    .abort_i        (abort),
    .cfg_w_base_i   (cfg_w_base),
    .cfg_a_base_i   (cfg_a_base),
    .cfg_words_i    (cfg_words),
    .cfg_num_outs_i (cfg_num_outs),
    .rd_req_o       (rd_req),
    .rd_gnt_i       (rd_gnt),
    .w_rd_addr_o    (w_addr),
    .a_rd_addr_o    (a_addr),
    .cast_valid_o   (cast_valid),
    .tag_x_o        (tag_x),
    .tag_y_o        (tag_y),
    .pe_start_o     (pe_start),
    .pe_done_i      (pe_done),
    .trigger_sums_o (trigger),
    .out_valid_i    (out_valid),
    .out_addr_o     (out_addr),
`ifdef PE_CLUSTER_PERF_EN
    .perf_cycles_o  (perf),
`endif
    .flag_done_o    (flag_done)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " rd_req"}, 64'(rd_req), 0);
    chk({tag, " cast_valid"}, 64'(cast_valid), 0);
    chk({tag, " w_addr"}, 64'(w_addr), 0);
    chk({tag, " a_addr"}, 64'(a_addr), 0);
    chk({tag, " tag_x"}, 64'(tag_x), 0);
    chk({tag, " tag_y"}, 64'(tag_y), 0);
    chk({tag, " pe_start"}, 64'(pe_start), 0);
    chk({tag, " trigger"}, 64'(trigger), 0);
    chk({tag, " out_addr"}, 64'(out_addr), 0);
    chk({tag, " flag_done"}, 64'(flag_done), 0);
  endtask

  // Load run checked against the reference order: word g of the stream goes to
  // PE column (g/words)%3, row (g/words)/3, at base+g.
  task automatic run_load(input int words, input logic [15:0] wb, input logic [15:0] ab,
                          input int gmode, input bit both, input int exp_req);
    int n = 9 * words;
    int g = 0, c = 0, last_cast = -1, flag_cyc = -1, req_cycles = 0, starts = 0;
    logic [15:0] ew, ea;
    cfg_words = 8'(words);
    cfg_w_base = wb;
    cfg_a_base = ab;
    start_load = 1'b1;
    start_compute = both;
    tick();
    start_load = 1'b0;
    start_compute = 1'b0;
    for (int cyc = 1; cyc < 300 && flag_cyc < 0; cyc++) begin
      case (gmode)
        0:       rd_gnt = 1'b1;
        1:       rd_gnt = (cyc % 2 == 0);
        default: rd_gnt = 1'($urandom_range(0, 1));
      endcase
      if (pe_start) starts++;
      if (rd_req) req_cycles++;
      if (rd_req && rd_gnt) begin
        if (g < n) begin
          ew = wb + 16'(g);
          ea = ab + 16'(g);
          chk("load w_addr", 64'(w_addr), 64'(ew));
          chk("load a_addr", 64'(a_addr), 64'(ea));
        end
        g++;
      end
      if (cast_valid) begin
        if (c < n) begin
          chk("cast tag_x", 64'(tag_x), 64'((c / words) % 3));
          chk("cast tag_y", 64'(tag_y), 64'((c / words) / 3));
        end
        c++;
        last_cast = cyc;
      end
      if (flag_done) flag_cyc = cyc;
      tick();
    end
    rd_gnt = 1'b0;
    chk("load grants", 64'(g), 64'(n));
    chk("load casts", 64'(c), 64'(n));
    chk("load no pe_start", 64'(starts), 0);
    if (exp_req >= 0) chk("load req cycles", 64'(req_cycles), 64'(exp_req));
    chk("load flag cycle", 64'(flag_cyc), 64'((n == 0) ? 3 : last_cast + 1));
    chk("load flag width", 64'(flag_done), 0);
  endtask

  // Compute/drain run: pe_done fully set from cycle 1+done_after; psums are sent
  // at random cycles once the trigger has been seen.
  task automatic run_compute(input int done_after, input int nouts, input bit inject);
    int starts = 0, trigs = 0, trig_cyc = -1, sent = 0, last_sent = -1, flag_cyc = -1;
    int exp_trig;
    cfg_num_outs = 8'(nouts);
    cfg_words = 8'd2;
    pe_done = 3'b011;
    start_compute = 1'b1;
    tick();
    start_compute = 1'b0;
    for (int cyc = 1; cyc < 300 && flag_cyc < 0; cyc++) begin
      pe_done = (cyc >= 1 + done_after) ? 3'b111 : 3'b011;
      if (pe_start) begin
        starts++;
        chk("pe_start cycle", 64'(cyc), 1);
      end
      if (trigger != 3'b000) begin
        trigs++;
        chk("trigger value", 64'(trigger), 64'(3'b111));
        trig_cyc = cyc;
      end
      if (flag_done) begin
        flag_cyc = cyc;
        chk("out_addr cleared", 64'(out_addr), 0);
      end else if (trig_cyc >= 0) begin
        chk("drain out_addr", 64'(out_addr), 64'(sent));
      end
      start_load = inject && (trig_cyc >= 0) && (cyc == trig_cyc + 1);
      out_valid = (trig_cyc >= 0) && (cyc > trig_cyc) && (sent < nouts) &&
                  1'($urandom_range(0, 1));
      if (out_valid) begin
        sent++;
        last_sent = cyc;
      end
      tick();
    end
    out_valid = 1'b0;
    start_load = 1'b0;
    pe_done = 3'b000;
    exp_trig = ((1 + done_after > 2) ? 1 + done_after : 2) + 1;
    chk("pe_start pulses", 64'(starts), 1);
    chk("trigger pulses", 64'(trigs), 1);
    chk("trigger cycle", 64'(trig_cyc), 64'(exp_trig));
    chk("drain flag cycle", 64'(flag_cyc), 64'(((nouts == 0) ? trig_cyc : last_sent) + 2));
    chk("drain flag width", 64'(flag_done), 0);
    chk("no queued load", 64'(rd_req), 0);
  endtask

  typedef struct {
    int          words;
    logic [15:0] wb;
    logic [15:0] ab;
    int          gmode;
    bit          both;
    int          exp_req;
  } vec_t;

  vec_t vt[5];

  initial begin
    vt[0] = '{2, 16'h0010, 16'h0080, 0, 1'b0, 18};
    vt[1] = '{2, 16'h0010, 16'h0080, 1, 1'b0, 36};
    vt[2] = '{1, 16'hFFFE, 16'hFFFB, 0, 1'b1, 9};
    vt[3] = '{0, 16'h1234, 16'h5678, 0, 1'b1, 0};
    vt[4] = '{3, 16'h0100, 16'h0200, 2, 1'b0, -1};

    nrst = 1'b0;
    start_load = 1'b0;
    start_compute = 1'b0;
    abort = 1'b0;
    cfg_w_base = '0;
    cfg_a_base = '0;
    cfg_words = '0;
    cfg_num_outs = '0;
    rd_gnt = 1'b0;
    pe_done = '0;
    out_valid = 1'b0;
    tick();
    tick();
    chk_all_zero("reset");
    nrst = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) begin
      run_load(vt[i].words, vt[i].wb, vt[i].ab, vt[i].gmode, vt[i].both, vt[i].exp_req);
`ifdef PE_CLUSTER_PERF_EN
      if (i == 0) chk("perf cycles", 64'(perf), 19);
`endif
      tick();
    end

    run_compute(5, 4, 1'b0);
    run_compute(0, 0, 1'b1);
    run_compute(2, 3, 1'b1);

    // Abort while computing: straight back to idle, no drain, no flag.
    pe_done = 3'b000;
    start_compute = 1'b1;
    tick();
    start_compute = 1'b0;
    tick();
    abort = 1'b1;
    pe_done = 3'b111;
    tick();
    abort = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("abort compute trigger", 64'(trigger), 0);
      chk("abort compute pe_start", 64'(pe_start), 0);
      chk("abort compute flag", 64'(flag_done), 0);
      tick();
    end
    pe_done = 3'b000;

    // Abort while loading: the in-flight grant casts once, then nothing.
    cfg_words = 8'd2;
    start_load = 1'b1;
    tick();
    start_load = 1'b0;
    rd_gnt = 1'b1;
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort load rd_req", 64'(rd_req), 0);
    chk("abort load inflight cast", 64'(cast_valid), 1);
    tick();
    chk("abort load single cast", 64'(cast_valid), 0);
    rd_gnt = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("abort load flag", 64'(flag_done), 0);
      tick();
    end

    // Asynchronous reset in the middle of a load.
    start_load = 1'b1;
    tick();
    start_load = 1'b0;
    rd_gnt = 1'b1;
    tick();
    tick();
    nrst = 1'b0;
    #1;
    chk_all_zero("midload reset");
    tick();
    nrst = 1'b1;
    rd_gnt = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("post reset rd_req", 64'(rd_req), 0);
      chk("post reset flag", 64'(flag_done), 0);
      tick();
    end

    // Randomized loads and compute/drain runs against the reference rules.
    for (int r = 0; r < 6; r++) begin
      run_load(int'($urandom_range(1, 3)), 16'($urandom), 16'($urandom), 2, 1'b0, -1);
      tick();
      run_compute(int'($urandom_range(0, 6)), int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
